ct_spsram_4096x128_ctrl: RTL and testbench

CT_SPSRAM_4096X128_CTRL -- requirements
Module: ct_spsram_4096x128_ctrl

---
 rtl/ct_spsram_ctrl_pkg.sv | 20 ++
 rtl/ct_spsram_4096x128_ctrl_if.sv | 30 +++
 rtl/ct_spsram_rsp_fifo.sv | 59 +++++
 rtl/ct_spsram_4096x128_ctrl.sv | 127 ++++++++++++
 tb/tb_ct_spsram_4096x128_ctrl.sv | 412 ++++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ct_spsram_ctrl_pkg.sv
// Shared definitions for the single-port SRAM controller slice.
//   ctrl_state_e   : controller FSM states (ERR_HOLD is reserved and behaves as RUN)
//   RSP_FIFO_DEPTH : number of read responses that can be buffered
//   state_is_run() : true for every state that accepts traffic
package ct_spsram_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_INIT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_ERR_HOLD = 2'd2
    } ctrl_state_e;

    localparam int RSP_FIFO_DEPTH = 2;

    // ERR_HOLD is never entered, but if it ever is it must act exactly like RUN.
    function automatic logic state_is_run(input ctrl_state_e s);
        return (s != ST_INIT);
    endfunction

endpackage

// File: rtl/ct_spsram_4096x128_ctrl_if.sv
// Request/response bundle between a traffic source and the SRAM controller.
//   req_* : write/read request channel (valid/ready)
//   rsp_* : read data channel (valid/ready)
//   init_done : zero-fill finished, traffic accepted
// master = requester side, slave = controller side.
interface ct_spsram_4096x128_ctrl_if #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128
);
    logic                  req_vld;
    logic                  req_rdy;
    logic                  req_wr;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic [DATA_WIDTH-1:0] req_wmask;
    logic                  rsp_vld;
    logic                  rsp_rdy;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  init_done;

    modport master (
        output req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        input  req_rdy, rsp_vld, rsp_rdata, init_done
    );

    modport slave (
        input  req_vld, req_wr, req_addr, req_wdata, req_wmask, rsp_rdy,
        output req_rdy, rsp_vld, rsp_rdata, init_done
    );
endinterface

// File: rtl/ct_spsram_rsp_fifo.sv
// Two-entry in-order read-response buffer.
//   forever_cpuclk / cpurst_b : clock, synchronous active-low reset
//   push, push_data           : write one entry (caller guarantees not full)
//   pop                       : drop the head entry (caller guarantees not empty)
//   vld, head_data            : non-empty flag and head entry
//   count                     : current occupancy (0..2)
module ct_spsram_rsp_fifo
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = 128
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] push_data,
    input  logic                  pop,
    output logic                  vld,
    output logic [DATA_WIDTH-1:0] head_data,
    output logic [1:0]            count
);

    logic [DATA_WIDTH-1:0] mem_reg [RSP_FIFO_DEPTH];
    logic                  wr_ptr_reg;
    logic                  rd_ptr_reg;
    logic [1:0]            cnt_reg;

    // Storage needs no reset: an entry is only read after it has been pushed.
    generate
        for (genvar gi = 0; gi < RSP_FIFO_DEPTH; gi++) begin : g_entry
            always_ff @(posedge forever_cpuclk) begin
                if (push && (wr_ptr_reg == 1'(gi))) begin
                    mem_reg[gi] <= push_data;
                end
            end
        end
    endgenerate

    // With depth 2 the pointers are single bits, so toggling is the modulo-2 wrap.
    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            wr_ptr_reg <= 1'b0;
            rd_ptr_reg <= 1'b0;
            cnt_reg    <= 2'd0;
        end else begin
            if (push) begin
                wr_ptr_reg <= ~wr_ptr_reg;
            end
            if (pop) begin
                rd_ptr_reg <= ~rd_ptr_reg;
            end
            cnt_reg <= cnt_reg + 2'(push) - 2'(pop);
        end
    end

    assign vld       = (cnt_reg != 2'd0);
    assign head_data = mem_reg[rd_ptr_reg];
    assign count     = cnt_reg;

endmodule

// File: rtl/ct_spsram_4096x128_ctrl.sv
// Controller in front of a 4096x128 single-port SRAM macro (A/CEN/GWEN/WEN/D/Q).
//   forever_cpuclk, cpurst_b : clock, synchronous active-low reset
//   req_*                    : request channel; writes are fire-and-forget
//   rsp_*                    : in-order read data, buffered two deep
//   init_done                : zero-fill done, traffic accepted
//   sram_*                   : direct connection to the SRAM macro pins
// After reset (INIT_EN=1) every word is written with zero, one per cycle, before
// any request is accepted.
module ct_spsram_4096x128_ctrl
    import ct_spsram_ctrl_pkg::*;
#(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 128,
    parameter int INIT_EN    = 1
) (
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    input  logic                  req_vld,
    output logic                  req_rdy,
    input  logic                  req_wr,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [DATA_WIDTH-1:0] req_wmask,
    output logic                  rsp_vld,
    input  logic                  rsp_rdy,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic [ADDR_WIDTH-1:0] sram_a,
    output logic                  sram_cen,
    output logic                  sram_gwen,
    output logic [DATA_WIDTH-1:0] sram_wen,
    output logic [DATA_WIDTH-1:0] sram_d,
    input  logic [DATA_WIDTH-1:0] sram_q
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR   = '1;
    localparam ctrl_state_e           RESET_STATE = (INIT_EN != 0) ? ST_INIT : ST_RUN;

    ctrl_state_e           state_reg, state_next;
    logic [ADDR_WIDTH-1:0] init_cnt_reg, init_cnt_next;
    logic                  rd_inflight_reg;

    logic                  in_run;
    logic                  init_wr;
    logic                  rd_room;
    logic                  req_acc;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  rsp_pop;
    logic                  fifo_vld;
    logic [1:0]            fifo_cnt;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            state_reg       <= RESET_STATE;
            init_cnt_reg    <= '0;
            rd_inflight_reg <= 1'b0;
        end else begin
            state_reg       <= state_next;
            init_cnt_reg    <= init_cnt_next;
            rd_inflight_reg <= rd_acc;
        end
    end

    always_comb begin
        state_next    = state_reg;
        init_cnt_next = init_cnt_reg;
        case (state_reg)
            ST_INIT: begin
                init_cnt_next = init_cnt_reg + ADDR_WIDTH'(1);
                if (init_cnt_reg == LAST_ADDR) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN:  state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
    end

    // Every output is forced idle while reset is held, independent of state.
    assign in_run  = state_is_run(state_reg);
    assign init_wr = cpurst_b & ~in_run;

    // A response popped this cycle frees its slot for a read issued this cycle;
    // the read still in flight (data on sram_q now) already owns a slot.
    assign rsp_pop = rsp_vld & rsp_rdy;
    assign rd_room = (fifo_cnt + 2'(rd_inflight_reg) - 2'(rsp_pop)) < 2'(RSP_FIFO_DEPTH);

    assign req_rdy = cpurst_b & in_run & (req_wr | rd_room);
    assign req_acc = req_vld & req_rdy;
    assign wr_acc  = req_acc & req_wr;
    assign rd_acc  = req_acc & ~req_wr;

    assign init_done = cpurst_b & in_run;
    assign rsp_vld   = cpurst_b & fifo_vld;

    assign sram_cen  = ~(init_wr | req_acc);
    assign sram_gwen = ~(init_wr | wr_acc);

    always_comb begin
        sram_a   = req_addr;
        sram_d   = req_wdata;
        sram_wen = '1;
        if (init_wr) begin
            sram_a   = init_cnt_reg;
            sram_d   = '0;
            sram_wen = '0;
        end else if (wr_acc) begin
            sram_wen = ~req_wmask;
        end
    end

    // sram_q carries the data of the read issued in the previous cycle.
    ct_spsram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_rsp_fifo (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .push           (rd_inflight_reg),
        .push_data      (sram_q),
        .pop            (rsp_pop),
        .vld            (fifo_vld),
        .head_data      (rsp_rdata),
        .count          (fifo_cnt)
    );

endmodule

// File: tb/tb_ct_spsram_4096x128_ctrl.sv
module tb_ct_spsram_4096x128_ctrl;

    localparam int AW    = 12;
    localparam int DW    = 128;
    localparam int DEPTH = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_b;
    logic [AW-1:0] sram_a;
    logic          sram_cen;
    logic          sram_gwen;
    logic [DW-1:0] sram_wen;
    logic [DW-1:0] sram_d;
    logic [DW-1:0] sram_q;

    ct_spsram_4096x128_ctrl_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    ct_spsram_4096x128_ctrl #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .INIT_EN    (1)
    ) dut (
        .forever_cpuclk (clk),
        .cpurst_b       (rst_b),
        .req_vld        (bus.req_vld),
        .req_rdy        (bus.req_rdy),
        .req_wr         (bus.req_wr),
        .req_addr       (bus.req_addr),
        .req_wdata      (bus.req_wdata),
        .req_wmask      (bus.req_wmask),
        .rsp_vld        (bus.rsp_vld),
        .rsp_rdy        (bus.rsp_rdy),
        .rsp_rdata      (bus.rsp_rdata),
        .init_done      (bus.init_done),
        .sram_a         (sram_a),
        .sram_cen       (sram_cen),
        .sram_gwen      (sram_gwen),
        .sram_wen       (sram_wen),
        .sram_d         (sram_d),
        .sram_q         (sram_q)
    );

    // SRAM macro model: bit-masked writes, registered read data. Words never
    // written read back as a non-zero filler so a missing zero-fill shows up.
    logic [DW-1:0] sram_mem [DEPTH];
    logic          sram_written [DEPTH];
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen) begin
                sram_mem[sram_a]     <= ((sram_written[sram_a] ? sram_mem[sram_a] : {4{32'hDEAD_BEEF}}) & sram_wen)
                                        | (sram_d & ~sram_wen);
                sram_written[sram_a] <= 1'b1;
            end else begin
                sram_q <= sram_written[sram_a] ? sram_mem[sram_a] : {4{32'hDEAD_BEEF}};
            end
        end
    end

    int n_cmp = 0;
    int n_bad = 0;

    // Scoreboard: reference memory (zero after fill), expected read data queue.
    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] exp_q [$];

    initial begin
        logic [DW-1:0] exp_data;
        forever begin
            @(negedge clk);
            if (!rst_b) begin
                exp_q.delete();
                for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
            end else begin
                if (bus.rsp_vld && bus.rsp_rdy) begin
                    n_cmp++;
                    if (exp_q.size() == 0) begin
                        n_bad++;
                        $display("FAIL scoreboard_pop: got unexpected response %h, required none", bus.rsp_rdata);
                    end else begin
                        exp_data = exp_q.pop_front();
                        if (bus.rsp_rdata !== exp_data) begin
                            n_bad++;
                            $display("FAIL scoreboard_data: got %h required %h", bus.rsp_rdata, exp_data);
                        end
                    end
                end
                if (bus.req_vld && bus.req_rdy) begin
                    if (bus.req_wr)
                        ref_mem[bus.req_addr] = (ref_mem[bus.req_addr] & ~bus.req_wmask)
                                                | (bus.req_wdata & bus.req_wmask);
                    else
                        exp_q.push_back(ref_mem[bus.req_addr]);
                end
            end
        end
    end

    function automatic logic [DW-1:0] pat(input logic [31:0] base, input int i);
        logic [31:0] w;
        w = base + 32'(i);
        return {w, ~w, w, ~w};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic vld, input logic wr, input logic [AW-1:0] addr,
                         input logic [DW-1:0] wdata, input logic [DW-1:0] wmask);
        bus.req_vld   = vld;
        bus.req_wr    = wr;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_wmask = wmask;
    endtask

    task automatic test_reset();
        rst_b       = 1'b0;
        bus.rsp_rdy = 1'b1;
        drive(1'b1, 1'b1, 12'h000, '1, '1);
        repeat (3) tick();
        @(negedge clk);
        n_cmp++;
        if (bus.req_rdy !== 1'b0 || bus.rsp_vld !== 1'b0 || bus.init_done !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got rdy/vld/done=%b%b%b required 000", bus.req_rdy, bus.rsp_vld, bus.init_done);
        end
        n_cmp++;
        if (sram_cen !== 1'b1 || sram_gwen !== 1'b1) begin
            n_bad++;
            $display("FAIL reset_sram_en: got cen/gwen=%b%b required 11", sram_cen, sram_gwen);
        end
        n_cmp++;
        if (sram_wen !== '1) begin
            n_bad++;
            $display("FAIL reset_sram_wen: got %h required all ones", sram_wen);
        end
        tick();
        drive(1'b0, 1'b1, 12'h000, '0, '0);
    endtask

    // Call right after releasing reset: expects 4096 zero writes in ascending
    // order, then init_done.
    task automatic test_init_fill(input string tag);
        int cycles = 0;
        int bad    = 0;
        bit done   = 1'b0;
        while (!done && cycles < 5000) begin
            @(negedge clk);
            if (bus.init_done) begin
                done = 1'b1;
            end else begin
                if (sram_cen !== 1'b0 || sram_gwen !== 1'b0 || sram_wen !== '0 || sram_d !== '0
                    || sram_a !== AW'(cycles) || bus.req_rdy !== 1'b0)
                    bad++;
                cycles++;
            end
        end
        n_cmp++;
        if (!done || cycles != DEPTH) begin
            n_bad++;
            $display("FAIL %s_init_cycles: got %0d cycles (done=%b) required 4096", tag, cycles, done);
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL %s_init_writes: got %0d bad fill cycles required 0", tag, bad);
        end
        tick();
    endtask

    task automatic test_init();
        rst_b = 1'b1;
        test_init_fill("first");
    endtask

    task automatic test_read_last();
        int wait_c = 0;
        bus.rsp_rdy = 1'b1;
        drive(1'b1, 1'b0, 12'hFFF, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (bus.req_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL read_last_rdy: got %b required 1", bus.req_rdy);
        end
        tick();
        drive(1'b0, 1'b0, 12'h000, '0, '0);
        @(negedge clk);
        while (!bus.rsp_vld && wait_c < 5) begin
            tick();
            @(negedge clk);
            wait_c++;
        end
        n_cmp++;
        if (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== '0) begin
            n_bad++;
            $display("FAIL read_last_data: got vld=%b data=%h required vld=1 data=0", bus.rsp_vld, bus.rsp_rdata);
        end
        tick();
    endtask

    task automatic test_write_read();
        logic [DW-1:0] a5 = {16{8'hA5}};
        bus.rsp_rdy = 1'b1;
        drive(1'b1, 1'b1, 12'h123, a5, '1);
        @(negedge clk);
        n_cmp++;
        if (bus.req_rdy !== 1'b1 || sram_gwen !== 1'b0 || sram_a !== 12'h123 || sram_wen !== '0) begin
            n_bad++;
            $display("FAIL wr_issue: got rdy=%b gwen=%b a=%h required 1 0 123", bus.req_rdy, sram_gwen, sram_a);
        end
        tick();
        drive(1'b1, 1'b0, 12'h123, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (bus.req_rdy !== 1'b1 || sram_cen !== 1'b0 || sram_gwen !== 1'b1 || sram_wen !== '1) begin
            n_bad++;
            $display("FAIL rd_issue: got rdy=%b cen=%b gwen=%b required 1 0 1", bus.req_rdy, sram_cen, sram_gwen);
        end
        tick();
        drive(1'b0, 1'b0, 12'h000, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_vld !== 1'b0 || sram_cen !== 1'b1) begin
            n_bad++;
            $display("FAIL rd_latency_early: got vld=%b cen=%b required 0 1", bus.rsp_vld, sram_cen);
        end
        tick();
        @(negedge clk);
        n_cmp++;
        if (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== a5) begin
            n_bad++;
            $display("FAIL wr_then_rd: got vld=%b data=%h required 1 %h", bus.rsp_vld, bus.rsp_rdata, a5);
        end
        tick();
    endtask

    task automatic test_wmask();
        logic [DW-1:0] mask = {{(DW-8){1'b0}}, 8'hFF};
        logic [DW-1:0] req  = {{(DW-8){1'b1}}, 8'h00};
        int wait_c = 0;
        bus.rsp_rdy = 1'b1;
        drive(1'b1, 1'b1, 12'h200, '1, '1);
        tick();
        drive(1'b1, 1'b1, 12'h200, '0, mask);
        tick();
        drive(1'b1, 1'b0, 12'h200, '0, '0);
        tick();
        drive(1'b0, 1'b0, 12'h000, '0, '0);
        @(negedge clk);
        while (!bus.rsp_vld && wait_c < 5) begin
            tick();
            @(negedge clk);
            wait_c++;
        end
        n_cmp++;
        if (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== req) begin
            n_bad++;
            $display("FAIL wmask: got vld=%b data=%h required 1 %h", bus.rsp_vld, bus.rsp_rdata, req);
        end
        tick();
    endtask

    task automatic test_backpressure();
        int  n_acc     = 0;
        int  stall_bad = 0;
        int  wait_c    = 0;
        bit  last_rdy  = 1'b1;
        bus.rsp_rdy = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, 1'b1, AW'(16 + i), pat(32'h1234_0000, i), '1);
            tick();
        end
        bus.rsp_rdy = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive(1'b1, 1'b0, AW'(16 + n_acc), '0, '0);
            @(negedge clk);
            if (bus.rsp_vld && bus.rsp_rdata !== pat(32'h1234_0000, 0))
                stall_bad++;
            last_rdy = bus.req_rdy;
            tick();
            if (last_rdy) n_acc++;
        end
        n_cmp++;
        if (n_acc != 2 || last_rdy !== 1'b0) begin
            n_bad++;
            $display("FAIL bp_accept: got %0d accepted (rdy=%b) required 2 (rdy=0)", n_acc, last_rdy);
        end
        n_cmp++;
        if (stall_bad != 0) begin
            n_bad++;
            $display("FAIL bp_hold: got %0d unstable head cycles required 0", stall_bad);
        end
        bus.rsp_rdy = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (bus.req_rdy !== 1'b1 || bus.rsp_vld !== 1'b1) begin
            n_bad++;
            $display("FAIL bp_pop_frees: got rdy=%b vld=%b required 1 1", bus.req_rdy, bus.rsp_vld);
        end
        tick();
        drive(1'b0, 1'b0, 12'h000, '0, '0);
        while ((bus.rsp_vld || exp_q.size() != 0) && wait_c < 10) begin
            tick();
            wait_c++;
        end
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL bp_drain: got %0d responses outstanding required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        int bad = 0;
        bus.rsp_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 1'b1, AW'(i), pat(32'hC0DE_0000, i), '1);
            tick();
        end
        for (int k = 0; k < 10; k++) begin
            if (k < 8) drive(1'b1, 1'b0, AW'(k), '0, '0);
            else       drive(1'b0, 1'b0, 12'h000, '0, '0);
            @(negedge clk);
            if (k < 8 && bus.req_rdy !== 1'b1) bad++;
            if (k < 2 && bus.rsp_vld !== 1'b0) bad++;
            if (k >= 2 && (bus.rsp_vld !== 1'b1 || bus.rsp_rdata !== pat(32'hC0DE_0000, k - 2))) begin
                bad++;
                $display("FAIL b2b_rsp%0d: got vld=%b data=%h required 1 %h", k - 2, bus.rsp_vld,
                         bus.rsp_rdata, pat(32'hC0DE_0000, k - 2));
            end
            tick();
        end
        n_cmp++;
        if (bad != 0) begin
            n_bad++;
            $display("FAIL back_to_back: got %0d bad cycles required 0", bad);
        end
    endtask

    task automatic test_reset_mid_op();
        bit seen_vld = 1'b0;
        bus.rsp_rdy = 1'b1;
        drive(1'b1, 1'b0, 12'h005, '0, '0);
        @(negedge clk);
        n_cmp++;
        if (bus.req_rdy !== 1'b1) begin
            n_bad++;
            $display("FAIL midop_rd_rdy: got %b required 1", bus.req_rdy);
        end
        tick();
        drive(1'b0, 1'b0, 12'h000, '0, '0);
        rst_b = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (bus.rsp_vld) seen_vld = 1'b1;
            tick();
        end
        rst_b = 1'b1;
        for (int c = 0; c <= 'h800; c++) begin
            @(negedge clk);
            if (bus.rsp_vld) seen_vld = 1'b1;
            if (c == 'h800) begin
                n_cmp++;
                if (sram_a !== 12'h800 || bus.init_done !== 1'b0) begin
                    n_bad++;
                    $display("FAIL midinit_addr: got a=%h done=%b required 800 0", sram_a, bus.init_done);
                end
            end
        end
        n_cmp++;
        if (seen_vld) begin
            n_bad++;
            $display("FAIL midop_drop: got rsp_vld=1 after reset required 0");
        end
        tick();
        rst_b = 1'b0;
        tick();
        rst_b = 1'b1;
        test_init_fill("restart");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_init();
        test_read_last();
        test_write_read();
        test_wmask();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_op();
        repeat (3) tick();
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_bad++;
            $display("FAIL final_drain: got %0d responses outstanding required 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
